// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation frame scheduler.
package me_pkg;

    localparam int SAD_BIT_WIDTH   = 14;
    localparam int COLD_BOOT_CYCLE = 24;
    localparam int FULL_CYCLE      = 23;
    localparam int BLK_COLS_DEF    = 482;
    localparam int BLK_ROWS_DEF    = 270;
    localparam int COORD_W_DEF     = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } me_state_e;

    typedef struct packed {
        logic [SAD_BIT_WIDTH-1:0] sad;
        logic [3:0]               idx;
        logic [COORD_W_DEF-1:0]   x;
        logic [COORD_W_DEF-1:0]   y;
    } me_result_t;

endpackage

// File: rtl/me_result_fifo.sv
// Two-deep result FIFO whose head entry is held directly in a register.
module me_result_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && (count_q != 2'd2);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = data_i;
                else                 tail_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Push and pop together only happens at count 1: the new entry becomes head.
            2'b11: head_d = data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/me_frame_scheduler.sv
// Frame sequencer for the ME core: boot/block timing, block coordinates and result queue.
//   state | meaning
//   IDLE  | waiting for start_i
//   BOOT  | cold-boot count up to the first block boundary
//   RUN   | one FULL_CYCLE count per block
//   DRAIN | last block pushed, waiting for queue to empty
//   DONE  | one-cycle done pulse
module me_frame_scheduler
    import me_pkg::*;
#(
    parameter int SAD_BIT_WIDTH   = me_pkg::SAD_BIT_WIDTH,
    parameter int BLK_COLS        = BLK_COLS_DEF,
    parameter int BLK_ROWS        = BLK_ROWS_DEF,
    parameter int COLD_BOOT_CYCLE = me_pkg::COLD_BOOT_CYCLE,
    parameter int FULL_CYCLE      = me_pkg::FULL_CYCLE,
    parameter int COORD_W         = COORD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     mem_ready_i,
    input  logic [SAD_BIT_WIDTH-1:0] msad_i,
    input  logic [3:0]               msad_index_i,
    output logic                     me_en_o,
    output logic [COORD_W-1:0]       blk_x_o,
    output logic [COORD_W-1:0]       blk_y_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [SAD_BIT_WIDTH-1:0] res_sad_o,
    output logic [3:0]               res_idx_o,
    output logic [COORD_W-1:0]       res_x_o,
    output logic [COORD_W-1:0]       res_y_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int CYC_MAX = (COLD_BOOT_CYCLE > FULL_CYCLE) ? COLD_BOOT_CYCLE : FULL_CYCLE;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int ENTRY_W = SAD_BIT_WIDTH + 4 + 2 * COORD_W;

    me_state_e          state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [COORD_W-1:0] blk_x_q, blk_x_d;
    logic [COORD_W-1:0] blk_y_q, blk_y_d;

    logic               me_en;
    logic               boundary;
    logic               last_blk;
    logic               pop;
    logic [1:0]         fifo_count;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] push_data;

    assign me_en    = ((state_q == ST_BOOT) || (state_q == ST_RUN))
                      && mem_ready_i && (fifo_count != 2'd2);
    assign boundary = me_en && (cyc_q == '0);
    assign last_blk = (blk_x_q == COORD_W'(BLK_COLS - 1)) && (blk_y_q == COORD_W'(BLK_ROWS - 1));
    assign pop      = fifo_valid && res_ready_i;
    assign push_data = {msad_i, msad_index_i, blk_x_q, blk_y_q};

    // Cycle counter runs down to zero; the zero cycle is the block boundary.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        blk_x_d = blk_x_q;
        blk_y_d = blk_y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BOOT;
                    cyc_d   = CYC_W'(COLD_BOOT_CYCLE - 1);
                    blk_x_d = '0;
                    blk_y_d = '0;
                end
            end
            ST_BOOT, ST_RUN: begin
                if (me_en) begin
                    if (cyc_q == '0) begin
                        cyc_d   = CYC_W'(FULL_CYCLE - 1);
                        state_d = last_blk ? ST_DRAIN : ST_RUN;
                        if (blk_x_q == COORD_W'(BLK_COLS - 1)) begin
                            blk_x_d = '0;
                            blk_y_d = (blk_y_q == COORD_W'(BLK_ROWS - 1)) ? '0 : blk_y_q + COORD_W'(1);
                        end else begin
                            blk_x_d = blk_x_q + COORD_W'(1);
                        end
                    end else begin
                        cyc_d = cyc_q - CYC_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            blk_x_q <= '0;
            blk_y_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            blk_x_q <= blk_x_d;
            blk_y_q <= blk_y_d;
        end
    end

    me_result_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (boundary),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign me_en_o     = me_en;
    assign blk_x_o     = blk_x_q;
    assign blk_y_o     = blk_y_q;
    assign res_valid_o = fifo_valid;
    assign res_sad_o   = fifo_head[ENTRY_W-1 -: SAD_BIT_WIDTH];
    assign res_idx_o   = fifo_head[2*COORD_W +: 4];
    assign res_x_o     = fifo_head[COORD_W +: COORD_W];
    assign res_y_o     = fifo_head[0 +: COORD_W];
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed bench for me_frame_scheduler on a 3x2-block frame.
module tb_me_frame_scheduler;
    import me_pkg::*;

    localparam int COLS = 3;
    localparam int ROWS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic [13:0] msad_i = '0;
    logic [3:0]  msad_index_i = '0;
    logic        res_ready_i = 1'b0;
    logic        me_en_o, res_valid_o, busy_o, done_o;
    logic [8:0]  blk_x_o, blk_y_o, res_x_o, res_y_o;
    logic [13:0] res_sad_o;
    logic [3:0]  res_idx_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    me_result_t exp_q[$];

    always #5 clk = ~clk;

    me_frame_scheduler #(
        .BLK_COLS (COLS),
        .BLK_ROWS (ROWS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mem_ready_i  (mem_ready_i),
        .msad_i       (msad_i),
        .msad_index_i (msad_index_i),
        .me_en_o      (me_en_o),
        .blk_x_o      (blk_x_o),
        .blk_y_o      (blk_y_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_sad_o    (res_sad_o),
        .res_idx_o    (res_idx_o),
        .res_x_o      (res_x_o),
        .res_y_o      (res_y_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Drives one cycle of inputs at the falling edge and settles before sampling.
    task automatic drive(input logic mr, input logic rr, input logic st);
        @(negedge clk);
        mem_ready_i  = mr;
        res_ready_i  = rr;
        start_i      = st;
        msad_i       = 14'((cyc * 37 + 11) % 16384);
        msad_index_i = 4'(cyc % 16);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_i = 1'b0;
        mem_ready_i = 1'b0;
        res_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    function automatic me_result_t head();
        me_result_t r;
        r.sad = res_sad_o;
        r.idx = res_idx_o;
        r.x   = res_x_o;
        r.y   = res_y_o;
        return r;
    endfunction

    function automatic me_result_t mk(input int x, input int y);
        me_result_t r;
        r.sad = msad_i;
        r.idx = msad_index_i;
        r.x   = 9'(x);
        r.y   = 9'(y);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (me_en_o !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", me_en_o); end
        checks++; if (blk_x_o !== 9'd0 || blk_y_o !== 9'd0) begin failures++; $display("FAIL reset_blk got=%0d,%0d exp=0,0", blk_x_o, blk_y_o); end
        checks++; if (res_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid_o); end
        checks++; if ({res_sad_o, res_idx_o, res_x_o, res_y_o} !== '0) begin failures++; $display("FAIL reset_res got=%h exp=0", {res_sad_o, res_idx_o, res_x_o, res_y_o}); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_o, done_o); end
    endtask

    task automatic test_single_frame();
        int en_cnt = 0, k = 0, pops = 0, dones = 0, last_pop = -10, bad_done = 0;
        do_reset();
        drive(1, 1, 1);
        for (int c = 0; c < 250; c++) begin
            drive(1, 1, 0);
            if (me_en_o) begin
                en_cnt++;
                if (k < 6 && en_cnt == 24 + 23 * k) begin
                    checks++;
                    if (blk_x_o !== 9'(k % COLS) || blk_y_o !== 9'(k / COLS)) begin
                        failures++; $display("FAIL frame_coord%0d got=%0d,%0d exp=%0d,%0d", k, blk_x_o, blk_y_o, k % COLS, k / COLS);
                    end
                    exp_q.push_back(mk(k % COLS, k / COLS));
                    k++;
                end
            end
            if (res_valid_o && res_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL frame_pop_unexpected got=%h exp=none", head());
                end else begin
                    if (head() !== exp_q[0]) begin failures++; $display("FAIL frame_result%0d got=%h exp=%h", pops, head(), exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                pops++;
                last_pop = c;
            end
            if (done_o) begin
                dones++;
                if (c != last_pop + 1) bad_done++;
            end
            if (dones > 0 && !busy_o) break;
        end
        checks++; if (k != 6) begin failures++; $display("FAIL frame_pushes got=%0d exp=6", k); end
        checks++; if (pops != 6) begin failures++; $display("FAIL frame_pops got=%0d exp=6", pops); end
        checks++; if (dones != 1 || bad_done != 0) begin failures++; $display("FAIL frame_done got=%0d pulses %0d late exp=1,0", dones, bad_done); end
        checks++; if (en_cnt != 139) begin failures++; $display("FAIL frame_enables got=%0d exp=139", en_cnt); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL frame_idle got=%b exp=0", busy_o); end
    endtask

    task automatic test_wrap();
        int en_cnt = 0;
        do_reset();
        drive(1, 1, 1);
        for (int c = 0; c < 200 && en_cnt < 70; c++) begin
            drive(1, 1, 0);
            if (me_en_o) en_cnt++;
        end
        checks++; if (en_cnt != 70) begin failures++; $display("FAIL wrap_timeout got=%0d exp=70", en_cnt); end
        checks++; if (blk_x_o !== 9'd2 || blk_y_o !== 9'd0) begin failures++; $display("FAIL wrap_before got=%0d,%0d exp=2,0", blk_x_o, blk_y_o); end
        drive(1, 1, 0);
        checks++; if (blk_x_o !== 9'd0 || blk_y_o !== 9'd1) begin failures++; $display("FAIL wrap_after got=%0d,%0d exp=0,1", blk_x_o, blk_y_o); end
    endtask

    task automatic test_backpressure();
        int en_cnt = 0, stall_en = 0;
        do_reset();
        drive(1, 0, 1);
        for (int c = 0; c < 200 && en_cnt < 47; c++) begin
            drive(1, 0, 0);
            if (me_en_o) begin
                en_cnt++;
                if (en_cnt == 24) exp_q.push_back(mk(0, 0));
                if (en_cnt == 47) exp_q.push_back(mk(1, 0));
            end
        end
        checks++; if (en_cnt != 47) begin failures++; $display("FAIL bp_timeout got=%0d exp=47", en_cnt); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0);
            if (me_en_o) stall_en++;
        end
        checks++; if (stall_en != 0) begin failures++; $display("FAIL bp_stall_en got=%0d exp=0", stall_en); end
        checks++; if (blk_x_o !== 9'd2) begin failures++; $display("FAIL bp_frozen_x got=%0d exp=2", blk_x_o); end
        checks++; if (res_valid_o !== 1'b1 || head() !== exp_q[0]) begin failures++; $display("FAIL bp_head0 got=%b/%h exp=1/%h", res_valid_o, head(), exp_q[0]); end
        drive(1, 1, 0);
        checks++; if (me_en_o !== 1'b0) begin failures++; $display("FAIL bp_full_en got=%b exp=0", me_en_o); end
        void'(exp_q.pop_front());
        drive(1, 0, 0);
        checks++; if (me_en_o !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%b exp=1", me_en_o); end
        if (me_en_o) en_cnt++;
        checks++; if (head() !== exp_q[0]) begin failures++; $display("FAIL bp_head1 got=%h exp=%h", head(), exp_q[0]); end
        for (int c = 0; c < 100 && en_cnt < 70; c++) begin
            drive(1, 0, 0);
            if (me_en_o) begin
                en_cnt++;
                if (en_cnt == 70) exp_q.push_back(mk(2, 0));
            end
        end
        drive(1, 0, 0);
        checks++; if (me_en_o !== 1'b0 || head() !== exp_q[0]) begin failures++; $display("FAIL bp_refill got=%b/%h exp=0/%h", me_en_o, head(), exp_q[0]); end
        drive(1, 1, 0);
        void'(exp_q.pop_front());
        drive(1, 0, 0);
        checks++; if (exp_q.size() != 1 || head() !== exp_q[0]) begin failures++; $display("FAIL bp_head2 got=%h exp=%h", head(), exp_q.size() ? exp_q[0] : '0); end
    endtask

    task automatic test_mem_toggle();
        int en_cnt = 0, first_valid = 0, bad_en = 0, bad_x = 0;
        logic mr;
        do_reset();
        drive(0, 1, 1);
        for (int c = 1; c < 100; c++) begin
            mr = (c % 2 == 1);
            drive(mr, 1, 0);
            if (res_valid_o) begin first_valid = c; break; end
            if (me_en_o !== mr) bad_en++;
            if (me_en_o) en_cnt++;
            else if (blk_x_o !== 9'd0) bad_x++;
        end
        checks++; if (first_valid != 48) begin failures++; $display("FAIL mem_first_valid got=%0d exp=48", first_valid); end
        checks++; if (en_cnt != 24) begin failures++; $display("FAIL mem_enables got=%0d exp=24", en_cnt); end
        checks++; if (bad_en != 0 || bad_x != 0) begin failures++; $display("FAIL mem_gating got=%0d/%0d exp=0/0", bad_en, bad_x); end
        checks++; if (blk_x_o !== 9'd1) begin failures++; $display("FAIL mem_advance got=%0d exp=1", blk_x_o); end
    endtask

    task automatic test_start_in_run();
        int en_cnt = 0;
        do_reset();
        drive(1, 1, 1);
        for (int c = 0; c < 100 && en_cnt < 30; c++) begin
            drive(1, 1, 0);
            if (me_en_o) en_cnt++;
        end
        drive(1, 1, 1);
        if (me_en_o) en_cnt++;
        drive(1, 1, 0);
        if (me_en_o) en_cnt++;
        checks++; if (blk_x_o !== 9'd1 || busy_o !== 1'b1) begin failures++; $display("FAIL run_start_coord got=%0d/%b exp=1/1", blk_x_o, busy_o); end
        for (int c = 0; c < 100 && en_cnt < 47; c++) begin
            drive(1, 1, 0);
            if (me_en_o) en_cnt++;
        end
        checks++; if (blk_x_o !== 9'd1) begin failures++; $display("FAIL run_start_boundary got=%0d exp=1", blk_x_o); end
        drive(1, 1, 0);
        checks++; if (blk_x_o !== 9'd2 || blk_y_o !== 9'd0) begin failures++; $display("FAIL run_start_next got=%0d,%0d exp=2,0", blk_x_o, blk_y_o); end
    endtask

    task automatic test_reset_mid_run();
        int en_cnt = 0;
        me_result_t r;
        do_reset();
        drive(1, 0, 1);
        for (int c = 0; c < 100 && en_cnt < 30; c++) begin
            drive(1, 0, 0);
            if (me_en_o) en_cnt++;
        end
        checks++; if (res_valid_o !== 1'b1) begin failures++; $display("FAIL abort_queued got=%b exp=1", res_valid_o); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({me_en_o, res_valid_o, busy_o, done_o} !== 4'b0) begin failures++; $display("FAIL abort_flags got=%b exp=0000", {me_en_o, res_valid_o, busy_o, done_o}); end
        checks++; if ({blk_x_o, blk_y_o, res_sad_o, res_idx_o, res_x_o, res_y_o} !== '0) begin failures++; $display("FAIL abort_data got=%h exp=0", {blk_x_o, blk_y_o, res_sad_o, res_idx_o, res_x_o, res_y_o}); end
        @(negedge clk);
        rst = 1'b1;
        en_cnt = 0;
        drive(1, 1, 1);
        for (int c = 0; c < 100 && en_cnt < 24; c++) begin
            drive(1, 1, 0);
            if (me_en_o) en_cnt++;
        end
        r = mk(0, 0);
        checks++; if (en_cnt != 24 || blk_x_o !== 9'd0 || blk_y_o !== 9'd0) begin failures++; $display("FAIL abort_restart got=%0d@%0d,%0d exp=24@0,0", en_cnt, blk_x_o, blk_y_o); end
        drive(1, 1, 0);
        checks++; if (res_valid_o !== 1'b1 || head() !== r) begin failures++; $display("FAIL abort_first_result got=%b/%h exp=1/%h", res_valid_o, head(), r); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_wrap();
        test_backpressure();
        test_mem_toggle();
        test_start_in_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
